// File: rtl/mips_fetch_stage.sv
// Mini-MIPS instruction fetch stage: PC, single-outstanding imem handshake, skid buffer, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module mips_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        flush,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt,
`endif
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic [31:0] id_instr,
   output logic [5:0]  id_opcode,
   output logic [4:0]  id_rs,
   output logic [4:0]  id_rt,
   output logic [4:0]  id_rd,
   output logic [4:0]  id_shamt,
   output logic [5:0]  id_funct,
   output logic [15:0] id_imm16,
   output logic [25:0] id_jtarget
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] skid_instr;
   logic [XLEN-1:0] skid_pc;
   logic            kill;
   logic            handshake;

   // Request is suppressed while decode stalls so no response can outrun the skid.
   assign imem_req  = (state == S_REQ) && !stall && !rst;
   assign imem_addr = pc;
   assign handshake = imem_req && imem_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_REQ;
         pc         <= RESET_PC;
         fetch_pc   <= '0;
         skid_instr <= '0;
         skid_pc    <= '0;
         kill       <= 1'b0;
         id_valid   <= 1'b0;
         id_instr   <= '0;
         id_pc      <= '0;
      end else if (redirect_valid) begin
         pc       <= {redirect_pc[XLEN-1:2], 2'b00};
         id_valid <= 1'b0;
         case (state)
            S_REQ: begin
               // Fetch accepted alongside a redirect is already on the wrong path.
               if (handshake) begin
                  fetch_pc <= pc;
                  kill     <= 1'b1;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  kill  <= 1'b0;
                  state <= S_REQ;
               end else begin
                  kill <= 1'b1;
               end
            end
            default: state <= S_REQ;
         endcase
      end else begin
         case (state)
            S_REQ: begin
               if (handshake) begin
                  fetch_pc <= pc;
                  pc       <= pc + STEP;
                  state    <= S_WAIT;
               end
               if (!stall) id_valid <= 1'b0;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  kill  <= 1'b0;
                  state <= S_REQ;
                  if (kill || flush) begin
                     if (!stall) id_valid <= 1'b0;
                  end else if (!stall) begin
                     id_valid <= 1'b1;
                     id_instr <= imem_rdata;
                     id_pc    <= fetch_pc;
                  end else begin
                     skid_instr <= imem_rdata;
                     skid_pc    <= fetch_pc;
                     state      <= S_HOLD;
                  end
               end else if (!stall) begin
                  id_valid <= 1'b0;
               end
            end
            default: begin
               if (flush) begin
                  state <= S_REQ;
               end else if (!stall) begin
                  id_valid <= 1'b1;
                  id_instr <= skid_instr;
                  id_pc    <= skid_pc;
                  state    <= S_REQ;
               end
            end
         endcase
         if (flush) id_valid <= 1'b0;
      end
   end

   assign id_pc_plus4 = id_pc + 32'd4;
   assign id_opcode   = id_instr[31:26];
   assign id_rs       = id_instr[25:21];
   assign id_rt       = id_instr[20:16];
   assign id_rd       = id_instr[15:11];
   assign id_shamt    = id_instr[10:6];
   assign id_funct    = id_instr[5:0];
   assign id_imm16    = id_instr[15:0];
   assign id_jtarget  = id_instr[25:0];

`ifdef FETCH_PERF_CNT_EN
   logic load_rsp_c;
   logic load_skid_c;

   assign load_rsp_c  = (state == S_WAIT) && imem_rvalid && !kill && !flush && !redirect_valid && !stall;
   assign load_skid_c = (state == S_HOLD) && !flush && !redirect_valid && !stall;

   // Counters wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (load_rsp_c || load_skid_c) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (stall && id_valid)         perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Random and scripted stimulus for mips_fetch_stage, checked against a transaction-level fetch model.
module tb_mips_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [31:0] id_instr;
   logic [5:0]  id_opcode;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [4:0]  id_shamt;
   logic [5:0]  id_funct;
   logic [15:0] id_imm16;
   logic [25:0] id_jtarget;

   int checks   = 0;
   int failures = 0;

   // Transaction-level model of the fetch pipeline.
   logic [31:0] m_pc;
   bit          m_busy, m_dead, m_held, m_idv;
   logic [31:0] m_faddr, m_hinstr, m_hpc, m_idi, m_idpc;

   // Memory responder: one pending access with a countdown.
   bit          mem_pend;
   logic [31:0] mem_addr;
   int          mem_cnt;
   int          lat_min = 0;
   int          lat_max = 0;

   mips_fetch_stage dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr),
      .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_shamt(id_shamt), .id_funct(id_funct), .id_imm16(id_imm16), .id_jtarget(id_jtarget)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h3C01_1234;
      if (a == 32'h4) return 32'h2002_0005;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic void model_reset();
      m_pc = 32'h0; m_busy = 0; m_dead = 0; m_held = 0; m_idv = 0;
      m_faddr = 0; m_hinstr = 0; m_hpc = 0; m_idi = 0; m_idpc = 0;
   endfunction

   // One clock of the reference: response handling, buffering, redirect and flush rules.
   function automatic void model_step(input bit st, input bit rd, input logic [31:0] rpc, input bit fl,
                                      input bit hs, input bit rv, input logic [31:0] rdata, input bit rs);
      logic [31:0] old_pc;
      bit          loaded;
      old_pc = m_pc;
      loaded = 0;
      if (rs) begin
         model_reset();
      end else if (rd) begin
         m_pc = {rpc[31:2], 2'b00};
         m_idv = 0; m_held = 0;
         if (hs) begin m_busy = 1; m_dead = 1; m_faddr = old_pc; end
         else if (m_busy && rv) begin m_busy = 0; m_dead = 0; end
         else if (m_busy) m_dead = 1;
      end else begin
         if (hs) begin
            m_busy = 1; m_dead = 0; m_faddr = old_pc; m_pc = old_pc + 32'd4;
         end else if (m_busy && rv) begin
            m_busy = 0;
            if (!m_dead && !fl) begin
               if (!st) begin m_idv = 1; m_idi = rdata; m_idpc = m_faddr; loaded = 1; end
               else begin m_held = 1; m_hinstr = rdata; m_hpc = m_faddr; end
            end
            m_dead = 0;
         end else if (m_held && !fl && !st) begin
            m_idv = 1; m_idi = m_hinstr; m_idpc = m_hpc; m_held = 0; loaded = 1;
         end
         if (fl) begin m_idv = 0; m_held = 0; end
         else if (!loaded && !st) m_idv = 0;
      end
   endfunction

   // Drive one cycle at posedge+1, check comb outputs at +2, registered outputs after the edge.
   task automatic do_cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit fl,
                           input bit rdy, input bit rs, input bit force_rv);
      bit          rv, mreq, hs;
      logic [31:0] rdata;
      rv    = (mem_pend && mem_cnt == 0) || force_rv;
      rdata = (mem_pend && mem_cnt == 0) ? mem_word(mem_addr) : $urandom;
      rst = rs; stall = st; redirect_valid = rd; redirect_pc = rpc; flush = fl;
      imem_ready = rdy; imem_rvalid = rv; imem_rdata = rdata;
      #1;
      mreq = !rs && !m_busy && !m_held && !st;
      check("imem_req", 32'(imem_req), 32'(mreq));
      check("imem_addr", imem_addr, m_pc);
      hs = mreq && rdy;
      if (rv) mem_pend = 0;
      else if (mem_pend) mem_cnt--;
      if (hs) begin
         mem_pend = 1; mem_addr = m_pc;
         mem_cnt = $urandom_range(lat_max, lat_min);
      end
      if (rs) mem_pend = 0;
      model_step(st, rd, rpc, fl, hs, rv, rdata, rs);
      @(posedge clk); #1;
      check("id_valid", 32'(id_valid), 32'(m_idv));
      check("id_instr", id_instr, m_idi);
      check("id_pc", id_pc, m_idpc);
      check("id_pc_plus4", id_pc_plus4, m_idpc + 32'd4);
      check("id_opcode", 32'(id_opcode), 32'(m_idi >> 26));
      check("id_rs", 32'(id_rs), (m_idi >> 21) & 32'h1F);
      check("id_rt", 32'(id_rt), (m_idi >> 16) & 32'h1F);
      check("id_rd", 32'(id_rd), (m_idi >> 11) & 32'h1F);
      check("id_shamt", 32'(id_shamt), (m_idi >> 6) & 32'h1F);
      check("id_funct", 32'(id_funct), m_idi & 32'h3F);
      check("id_imm16", 32'(id_imm16), m_idi & 32'hFFFF);
      check("id_jtarget", 32'(id_jtarget), m_idi & 32'h03FF_FFFF);
   endtask

   task automatic idle(input bit st, input bit rdy);
      do_cycle(st, 0, 32'h0, 0, rdy, 0, 0);
   endtask

   initial begin
      rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0; flush = 0;
      imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
      mem_pend = 0; mem_addr = 0; mem_cnt = 0;
      model_reset();
      @(posedge clk); #1;

      // Reset and first fetch with the LUI word, memory slow to accept.
      do_cycle(0, 0, 0, 0, 1, 1, 0);
      do_cycle(0, 0, 0, 0, 1, 1, 0);
      check("rst_id_valid", 32'(id_valid), 32'h0);
      repeat (3) idle(0, 0);
      check("hold_addr", imem_addr, 32'h0);
      idle(0, 1);
      idle(0, 0);
      check("lui_valid", 32'(id_valid), 32'h1);
      check("lui_opcode", 32'(id_opcode), 32'h0F);
      check("lui_rt", 32'(id_rt), 32'h1);
      check("lui_imm16", 32'(id_imm16), 32'h1234);
      check("next_addr", imem_addr, 32'h4);

      // Response under stall goes to the skid and is released afterwards.
      idle(0, 1);
      idle(1, 0);
      check("stall_keep", id_instr, 32'h3C01_1234);
      idle(1, 0);
      idle(0, 0);
      check("skid_instr", id_instr, 32'h2002_0005);
      check("skid_pc", id_pc, 32'h4);

      // Redirect while waiting discards the returning word.
      lat_min = 1; lat_max = 1;
      idle(0, 1);
      do_cycle(0, 1, 32'h0000_0042, 0, 0, 0, 0);
      idle(0, 0);
      check("redir_addr", imem_addr, 32'h40);
      lat_min = 0; lat_max = 0;
      idle(0, 1);
      idle(0, 0);
      check("redir_pc", id_pc, 32'h40);

      // Flush while the skid holds an instruction.
      idle(0, 1);
      idle(1, 0);
      do_cycle(1, 0, 0, 1, 0, 0, 0);
      check("flush_valid", 32'(id_valid), 32'h0);
      check("flush_addr", imem_addr, 32'h48);

      // PC wrap at the top of the address space.
      do_cycle(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      idle(0, 1);
      idle(0, 0);
      check("wrap_plus4", id_pc_plus4, 32'h0);
      check("wrap_addr", imem_addr, 32'h0);

      // Reset with a fetch in flight; the late response must be ignored.
      lat_min = 1; lat_max = 1;
      idle(0, 1);
      do_cycle(0, 0, 0, 0, 0, 1, 0);
      do_cycle(0, 0, 0, 0, 0, 0, 1);
      check("late_rv_valid", 32'(id_valid), 32'h0);
      check("late_rv_addr", imem_addr, 32'h0);

      // Random traffic.
      lat_min = 0; lat_max = 3;
      for (int i = 0; i < 4000; i++) begin
         bit          st, rd, fl, rdy, rs;
         logic [31:0] rpc;
         st  = ($urandom_range(3, 0) == 0);
         rd  = ($urandom_range(15, 0) == 0);
         fl  = ($urandom_range(15, 0) == 0);
         rdy = ($urandom_range(3, 0) != 0);
         rs  = ($urandom_range(299, 0) == 0);
         rpc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFC - 32'($urandom_range(7, 0)) : 32'($urandom_range(1023, 0));
         do_cycle(st, rd, rpc, fl, rdy, rs, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
